run_monitor: RTL and testbench

Parametrised run-control and retirement monitor for the xgriscv pipeline simulation environment. It watches the writeback-stage PC stream and counts cycles and retired instructions. It ends a run on one of three events: a match against any of several programmable halt addresses, a global cycle timeout, or a retirement stall (hang). It sits beside `xgriscv_pipeline`, taking `pcW` plus a retire-valid strobe, and gives the bench or online judge a single registered `done` with a cause code.

---
 rtl/run_monitor.sv | 117 +++++++++++
 tb/tb_run_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// Run-control monitor: ends a simulation run on halt-address match, cycle timeout or retirement hang.
// Latency: a terminating event sampled at edge k is visible on state/done right after edge k.
// Backpressure: none; a pure observer that never stalls the pipeline and accepts pcw every cycle.
//
// Ports:
//   clk, rstn        clock and synchronous active-high reset (1 = reset)
//   pcw, pcw_valid   writeback PC and retire strobe
//   halt_addr/_en    flat halt comparator addresses and per-comparator enables
//   state/done/pass  run state (00 RUN, 01 HALT, 10 TIMEOUT, 11 HANG) and decoded flags
//   halt_idx         lowest comparator index that caused the halt
//   cycle_cnt/instr_cnt/last_pc  run statistics, frozen once the run ends
module run_monitor #(
   parameter int ADDR_W     = 32,
   parameter int NUM_HALT   = 2,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 100000,
   parameter int HANG_LIMIT = 1024
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [ADDR_W-1:0]          pcw,
   input  logic                       pcw_valid,
   input  logic [NUM_HALT*ADDR_W-1:0] halt_addr,
   input  logic [NUM_HALT-1:0]        halt_en,
   output logic [1:0]                 state,
   output logic                       done,
   output logic                       pass,
   output logic [2:0]                 halt_idx,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [CNT_W-1:0]           instr_cnt,
   output logic [ADDR_W-1:0]          last_pc
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_HALT    = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_HANG    = 2'b11
   } state_t;

   state_t            st_q, st_d;
   logic [CNT_W-1:0]  cyc_q, ins_q, idle_q;
   logic [ADDR_W-1:0] last_q;
   logic [2:0]        idx_q;

   logic              match_any;
   logic [2:0]        match_idx;
   logic              halt_hit, hang_hit, to_hit;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Scan from the top down so the lowest matching comparator is the one left standing.
   always_comb begin
      match_any = 1'b0;
      match_idx = 3'd0;
      for (int i = NUM_HALT - 1; i >= 0; i--) begin
         if (halt_en[i] && (pcw == halt_addr[i*ADDR_W +: ADDR_W])) begin
            match_any = 1'b1;
            match_idx = 3'(i);
         end
      end
   end

   // idle_q holds the idle edges already seen, so the HANG_LIMIT-th idle edge sees HANG_LIMIT-1.
   assign halt_hit = pcw_valid && match_any;
   assign hang_hit = !pcw_valid && (idle_q == CNT_W'(HANG_LIMIT - 1));
   assign to_hit   = (cyc_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rstn) st_q <= ST_RUN;
      else      st_q <= st_d;
   end

   // Next state and decoded outputs; terminal states hold until reset.
   always_comb begin
      st_d  = st_q;
      state = st_q;
      done  = (st_q != ST_RUN);
      pass  = (st_q == ST_HALT);
      if (st_q == ST_RUN) begin
         if (halt_hit)      st_d = ST_HALT;
         else if (hang_hit) st_d = ST_HANG;
         else if (to_hit)   st_d = ST_TIMEOUT;
      end
   end

   // Statistics advance only in RUN, including the edge that ends the run.
   always_ff @(posedge clk) begin
      if (rstn) begin
         cyc_q  <= '0;
         ins_q  <= '0;
         idle_q <= '0;
         last_q <= '0;
         idx_q  <= 3'd0;
      end else if (st_q == ST_RUN) begin
         cyc_q <= sat_inc(cyc_q);
         if (pcw_valid) begin
            ins_q  <= sat_inc(ins_q);
            last_q <= pcw;
            idle_q <= '0;
         end else begin
            idle_q <= sat_inc(idle_q);
         end
         if (halt_hit) idx_q <= match_idx;
      end
   end

   assign halt_idx  = idx_q;
   assign cycle_cnt = cyc_q;
   assign instr_cnt = ins_q;
   assign last_pc   = last_q;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

   localparam int AW = 32;
   localparam int NH = 3;
   localparam int CW = 32;
   localparam int TO = 50;
   localparam int HL = 8;

   logic               clk = 1'b0;
   logic               rstn;
   logic [AW-1:0]      pcw;
   logic               pcw_valid;
   logic [NH*AW-1:0]   halt_addr;
   logic [NH-1:0]      halt_en;
   logic [1:0]         state;
   logic               done;
   logic               pass;
   logic [2:0]         halt_idx;
   logic [CW-1:0]      cycle_cnt;
   logic [CW-1:0]      instr_cnt;
   logic [AW-1:0]      last_pc;

   int checks = 0;
   int failures = 0;

   // Reference model: run outcome expressed as counts and "edge of last retirement".
   int          m_state;
   longint      m_cyc, m_ins, m_last_ret;
   logic [AW-1:0] m_last;
   int          m_idx;

   always #5 clk = ~clk;

   run_monitor #(
      .ADDR_W(AW), .NUM_HALT(NH), .CNT_W(CW), .TIMEOUT(TO), .HANG_LIMIT(HL)
   ) dut (
      .clk(clk), .rstn(rstn), .pcw(pcw), .pcw_valid(pcw_valid),
      .halt_addr(halt_addr), .halt_en(halt_en),
      .state(state), .done(done), .pass(pass), .halt_idx(halt_idx),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .last_pc(last_pc)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply the run rules to the inputs present at this edge.
   task automatic model_edge();
      int     hit;
      longint edge_no;
      bit     h, g, t;
      hit = -1;
      if (rstn) begin
         m_state = 0; m_cyc = 0; m_ins = 0; m_last_ret = 0; m_last = '0; m_idx = 0;
      end else if (m_state == 0) begin
         for (int i = 0; i < NH; i++)
            if (hit < 0 && halt_en[i] && halt_addr[i*AW +: AW] == pcw) hit = i;
         edge_no = m_cyc + 1;
         h = pcw_valid && (hit >= 0);
         g = !pcw_valid && (edge_no - m_last_ret == HL);
         t = (edge_no == TO);
         m_cyc = edge_no;
         if (pcw_valid) begin
            m_ins++;
            m_last = pcw;
            m_last_ret = edge_no;
         end
         if (h) begin
            m_state = 1;
            m_idx = hit;
         end else if (g) m_state = 3;
         else if (t) m_state = 2;
      end
   endtask

   task automatic compare_all();
      check("state", 64'(state), 64'(m_state));
      check("done", 64'(done), 64'(m_state != 0));
      check("pass", 64'(pass), 64'(m_state == 1));
      check("halt_idx", 64'(halt_idx), 64'(m_idx));
      check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      check("instr_cnt", 64'(instr_cnt), 64'(m_ins));
      check("last_pc", 64'(last_pc), 64'(m_last));
   endtask

   task automatic tick(input logic r, input logic v, input logic [AW-1:0] pc);
      rstn = r;
      pcw_valid = v;
      pcw = pc;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic set_halt(input int i, input logic [AW-1:0] a);
      halt_addr[i*AW +: AW] = a;
   endtask

   localparam logic [AW-1:0] BASE = 32'h8000_0000;

   initial begin
      rstn = 1'b1; pcw_valid = 1'b0; pcw = '0; halt_addr = '0; halt_en = '0;
      m_state = 0; m_cyc = 0; m_ins = 0; m_last_ret = 0; m_last = '0; m_idx = 0;

      // Halt address run
      set_halt(0, 32'h8000_0078);
      halt_en = 3'b001;
      tick(1, 0, 0);
      tick(1, 0, 0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      for (int i = 0; i <= 30; i++) tick(0, 1, BASE + AW'(4 * i));
      check("halt_state", 64'(state), 64'd1);
      check("halt_pass", 64'(pass), 64'd1);
      check("halt_idx0", 64'(halt_idx), 64'd0);
      check("halt_icnt", 64'(instr_cnt), 64'd31);
      check("halt_lastpc", 64'(last_pc), 64'h8000_0078);
      for (int i = 0; i < 5; i++) tick(0, 1, BASE + AW'(4 * (40 + i)));
      check("frozen_icnt", 64'(instr_cnt), 64'd31);
      check("frozen_ccnt", 64'(cycle_cnt), 64'd31);

      // Comparator priority / enable
      set_halt(0, 32'h8000_0010);
      set_halt(1, 32'h8000_0010);
      for (int e = 0; e < 3; e++) begin
         halt_en = (e == 0) ? 3'b010 : (e == 1) ? 3'b011 : 3'b000;
         tick(1, 0, 0);
         for (int i = 0; i < 5; i++) tick(0, 1, BASE + AW'(4 * i));
         if (e == 0) check("prio_en10", 64'(halt_idx), 64'd1);
         if (e == 1) check("prio_en11", 64'(halt_idx), 64'd0);
         check("prio_state", 64'(state), (e == 2) ? 64'd0 : 64'd1);
      end

      // Timeout: retire every cycle, never match
      halt_en = 3'b000;
      tick(1, 0, 0);
      for (int i = 0; i < TO; i++) begin
         tick(0, 1, BASE + AW'(4 * i));
         if (i == TO - 2) check("to_pre", 64'(state), 64'd0);
      end
      check("to_state", 64'(state), 64'd2);
      check("to_ccnt", 64'(cycle_cnt), 64'(TO));
      check("to_icnt", 64'(instr_cnt), 64'(TO));

      // Hang, with pcw equal to an enabled halt address while invalid
      set_halt(0, 32'h8000_0100);
      halt_en = 3'b001;
      tick(1, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 1, BASE + AW'(4 * i));
      for (int i = 0; i < HL; i++) begin
         tick(0, 0, 32'h8000_0100);
         if (i == HL - 2) check("hang_pre", 64'(state), 64'd0);
      end
      check("hang_state", 64'(state), 64'd3);
      check("hang_icnt", 64'(instr_cnt), 64'd3);

      // Hang variant: retirement at idle 7 restarts the count
      tick(1, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 1, BASE + AW'(4 * i));
      for (int i = 0; i < HL - 1; i++) tick(0, 0, 0);
      tick(0, 1, BASE + 32'h40);
      for (int i = 0; i < HL - 1; i++) tick(0, 0, 0);
      check("hang2_pre", 64'(state), 64'd0);
      tick(0, 0, 0);
      check("hang2_state", 64'(state), 64'd3);
      check("hang2_icnt", 64'(instr_cnt), 64'd4);

      // Halt and timeout on the same edge: halt wins
      tick(1, 0, 0);
      for (int i = 0; i < TO - 1; i++) tick(0, 1, BASE + AW'(4 * i));
      tick(0, 1, 32'h8000_0100);
      check("sim_halt", 64'(state), 64'd1);

      // Hang and timeout on the same edge: hang wins
      tick(1, 0, 0);
      for (int i = 0; i < TO - HL; i++) tick(0, 1, BASE + AW'(4 * i));
      for (int i = 0; i < HL; i++) tick(0, 0, 0);
      check("sim_hang", 64'(state), 64'd3);
      check("sim_hang_ccnt", 64'(cycle_cnt), 64'(TO));

      // Reset mid-run, in HALT, and on the same edge as a halt match
      tick(1, 0, 0);
      for (int i = 0; i < 19; i++) tick(0, 1, BASE + AW'(4 * i));
      tick(1, 1, BASE);
      check("rst_mid_ccnt", 64'(cycle_cnt), 64'd0);
      check("rst_mid_lpc", 64'(last_pc), 64'd0);
      for (int i = 0; i < 3; i++) tick(0, 1, BASE + AW'(4 * i));
      check("restart_ccnt", 64'(cycle_cnt), 64'd3);
      tick(0, 1, 32'h8000_0100);
      check("pre_rst_halt", 64'(state), 64'd1);
      tick(1, 1, 32'h8000_0100);
      check("rst_halt_state", 64'(state), 64'd0);
      check("rst_halt_icnt", 64'(instr_cnt), 64'd0);

      // Randomised runs
      for (int r = 0; r < 25; r++) begin
         int vprob;
         vprob = $urandom_range(5, 100);
         for (int i = 0; i < NH; i++) set_halt(i, BASE + AW'(4 * $urandom_range(0, 15)));
         halt_en = NH'($urandom);
         tick(1, 0, 0);
         for (int c = 0; c < 70; c++) begin
            if ($urandom_range(0, 9) == 0) begin
               set_halt($urandom_range(0, NH - 1), BASE + AW'(4 * $urandom_range(0, 15)));
               halt_en = NH'($urandom);
            end
            tick(($urandom_range(0, 59) == 0), ($urandom_range(1, 100) <= vprob),
                 BASE + AW'(4 * $urandom_range(0, 15)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
